hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised successor of the pipeline hazard/forwarding unit for the 5-stage MIPS core. Adds memory wait-state freezing, scoreboarding for a multi-cycle multiply/divide unit (MDU) and a saturating stall-cycle counter.
- Covers the full case matrix for forwarding, load-use stalls and branch stalls.
- Sits beside the datapath and drives the stall/flush enables of every pipeline register plus the forwarding mux selects.

Parameters:
- REG_AW, 5, register-address width (32 GPRs)
- MDU_LAT, 4, cycles an MDU operation occupies after issue from E (>=1)
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- BranchD  in  1  branch in Decode
- PcSrcD  in  1  branch/jump taken in Decode
- RsD, RtD  in  REG_AW  Decode source registers
- RsE, RtE  in  REG_AW  Execute source registers
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1  write enables
- MemtoRegE, MemtoRegM  in  1  load in stage
- MemReqM  in  1  data-memory access in Memory stage
- MemReadyM  in  1  data memory completes this cycle
- MduStartE  in  1  MDU operation issuing from Execute
- MduUseD  in  1  Decode instruction is an MDU op or mfhi/mflo
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  insert bubble
- ForwardAD, ForwardBD  out  1  Decode compare forwarding from M
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- MduBusy  out  1  MDU occupied
- StallCount  out  CNT_W  total cycles with StallF asserted

Behaviour:
- Reset (async, any time): MduBusy=0, mdu_cnt=0, StallCount=0. Every combinational output is 0 when its inputs are 0. Reset mid-MDU-op aborts the op; no stall survives reset.
- Forwarding (combinational):
  - Register 0 is never forwarded.
  - ForwardAE=10 if RsE==WriteRegM & RegWriteM; else 01 if RsE==WriteRegW & RegWriteW; else 00.
  - M takes priority over W. ForwardBE is the same rule with RtE.
  - ForwardAD/BD = RsD/RtD nonzero, equal to WriteRegM, and RegWriteM.
- lwstall = MemtoRegE & RtE!=0 & (RsD==RtE | RtD==RtE).
- branchstall = BranchD & [(RegWriteE & WriteRegE!=0 & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM!=0 & WriteRegM∈{RsD,RtD})].
- mdustall = MduUseD & MduBusy.
- memstall = MemReqM & ~MemReadyM.
- Priority and effects:
  - memstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. All other stalls are masked.
  - Else if lwstall|branchstall|mdustall: StallF=StallD=1, FlushE=1, StallE=StallM=0, FlushD=0.
  - Else: FlushD=PcSrcD; all other outputs 0.
- MDU scoreboard:
  - Issue is accepted when MduStartE & ~memstall. On issue, mdu_cnt loads MDU_LAT and MduBusy=1 from the next edge.
  - Each following cycle mdu_cnt decrements; MduBusy = (mdu_cnt!=0).
  - Result: an MduUseD instruction one cycle behind an issue stalls exactly MDU_LAT cycles.
  - The counter keeps decrementing during memstall (the MDU is independent).
  - An issue while busy (illegal, blocked by mdustall) reloads the counter and is reported by a simulation-only assertion.
- StallCount: +1 on every edge where StallF=1; saturates at all-ones and does not wrap.
- Simultaneous events:
  - memstall together with a load-use hazard: the freeze wins, and lwstall re-evaluates when MemReadyM rises.
  - PcSrcD together with a D stall: FlushD=0, because the branch resolves after the stall clears.

Decomposition:
- Shared package pipe_pkg: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, and the REG_AW default.
- One sub-module: mdu_scoreboard (counter, MduBusy, issue-while-busy assertion).
- Forwarding and stall logic stay in the top module.

Test Plan:
- lw $2 in E (RtE=2, MemtoRegE=1), RsD=2 -> StallF=StallD=FlushE=1 for 1 cycle. Next cycle ForwardAE=01 toward the dependent instruction. StallCount=1.
- RsE=5 with WriteRegM=5/RegWriteM=1 and WriteRegW=5/RegWriteW=1 -> ForwardAE=10. Same with RsE=0 -> ForwardAE=00.
- BranchD=1, RsD=3, WriteRegE=3, RegWriteE=1 -> stall 1 cycle. Next cycle ForwardAD=1 (WriteRegM=3). Then PcSrcD=1 -> FlushD=1 for 1 cycle.
- MduStartE pulse, then MduUseD=1 -> MduBusy high 4 cycles and StallD high 4 cycles (MDU_LAT=4). Reset asserted at cycle 2 -> MduBusy=0 immediately.
- MemReqM=1, MemReadyM=0 for 3 cycles with lwstall also true -> StallF/D/E/M=1, FlushW=1, FlushE=0 for 3 cycles. Then the load-use stall for 1 cycle. StallCount=4.
- CNT_W=3 with 10 continuous stall cycles -> StallCount=7 held.

Source files
------------

// File: rtl/hazard_unit_mc_pkg.sv
// Shared pipeline constants for the MIPS hazard unit.
// Forwarding select encodings and the default register-address width.
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // M beats W: the younger producer holds the newest value
    function automatic logic [1:0] fwd_sel(
        input logic hit_m,
        input logic hit_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_m)
            sel = FWD_M;
        else if (hit_w)
            sel = FWD_W;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit bundle.
// master is the datapath side, slave is the hazard unit.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              BranchD;
    logic              PcSrcD;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic [REG_AW-1:0] RsE;
    logic [REG_AW-1:0] RtE;
    logic [REG_AW-1:0] WriteRegE;
    logic [REG_AW-1:0] WriteRegM;
    logic [REG_AW-1:0] WriteRegW;
    logic              RegWriteE;
    logic              RegWriteM;
    logic              RegWriteW;
    logic              MemtoRegE;
    logic              MemtoRegM;
    logic              MemReqM;
    logic              MemReadyM;
    logic              MduStartE;
    logic              MduUseD;

    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              StallM;
    logic              FlushD;
    logic              FlushE;
    logic              FlushW;
    logic              ForwardAD;
    logic              ForwardBD;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              MduBusy;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output BranchD, PcSrcD, RsD, RtD, RsE, RtE,
        output WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW,
        output MemtoRegE, MemtoRegM, MemReqM, MemReadyM,
        output MduStartE, MduUseD,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
        input  MduBusy, StallCount
    );

    modport slave (
        input  BranchD, PcSrcD, RsD, RtD, RsE, RtE,
        input  WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  MemtoRegE, MemtoRegM, MemReqM, MemReadyM,
        input  MduStartE, MduUseD,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
        output MduBusy, StallCount
    );

endinterface

// File: rtl/hazard_unit_mc_mdu_scoreboard.sv
// Tracks occupancy of the multi-cycle multiply/divide unit.
// Busy for MDU_LAT cycles after each accepted issue.
module mdu_scoreboard #(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic busy
);
    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(MDU_LAT);

    logic [CW-1:0] mdu_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mdu_cnt <= '0;
        else if (issue)
            mdu_cnt <= LAT;
        else if (mdu_cnt != '0)
            mdu_cnt <= mdu_cnt - 1'b1;
    end

    assign busy = (mdu_cnt != '0);

    // Decode holds MDU ops while busy, so a new issue here is a datapath bug
    a_issue_while_busy: assert property (
        @(posedge clk) disable iff (reset) !(issue && busy)
    );

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline.
// Adds memory freeze, MDU scoreboard and a stall-cycle counter.
module hazard_unit_mc
    import pipe_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_unit_mc_if.slave   hz
);
    logic [REG_AW-1:0] rsd, rtd, rse, rte;
    logic [REG_AW-1:0] wre, wrm, wrw;

    assign rsd = hz.RsD;
    assign rtd = hz.RtD;
    assign rse = hz.RsE;
    assign rte = hz.RtE;
    assign wre = hz.WriteRegE;
    assign wrm = hz.WriteRegM;
    assign wrw = hz.WriteRegW;

    logic wrm_ok, wrw_ok;
    assign wrm_ok = hz.RegWriteM && (wrm != '0);
    assign wrw_ok = hz.RegWriteW && (wrw != '0);

    assign hz.ForwardAE = fwd_sel(
        wrm_ok && (rse == wrm), wrw_ok && (rse == wrw));
    assign hz.ForwardBE = fwd_sel(
        wrm_ok && (rte == wrm), wrw_ok && (rte == wrw));

    assign hz.ForwardAD = wrm_ok && (rsd == wrm);
    assign hz.ForwardBD = wrm_ok && (rtd == wrm);

    logic lwstall, branchstall, mdustall, memstall;
    logic e_hit, m_hit, dstall;
    logic mdu_busy;

    assign lwstall = hz.MemtoRegE && (rte != '0) &&
                     ((rsd == rte) || (rtd == rte));

    assign e_hit = hz.RegWriteE && (wre != '0) &&
                   ((wre == rsd) || (wre == rtd));
    assign m_hit = hz.MemtoRegM && (wrm != '0) &&
                   ((wrm == rsd) || (wrm == rtd));
    assign branchstall = hz.BranchD && (e_hit || m_hit);

    assign mdustall = hz.MduUseD && mdu_busy;
    assign memstall = hz.MemReqM && !hz.MemReadyM;
    assign dstall   = lwstall || branchstall || mdustall;

    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        priority case (1'b1)
            // whole pipe freezes; W is bubbled so nothing retires twice
            memstall: begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end
            dstall: begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
            default: hz.FlushD = hz.PcSrcD;
        endcase
    end

    mdu_scoreboard #(
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk   (clk),
        .reset (reset),
        .issue (hz.MduStartE && !memstall),
        .busy  (mdu_busy)
    );

    assign hz.MduBusy = mdu_busy;

    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (hz.StallF && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign hz.StallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc.
// Second instance uses CNT_W=3 to exercise counter saturation.
module tb_hazard_unit_mc;

    logic clk;
    logic reset;
    int   ncmp;
    int   nfail;

    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(16)) hz ();
    hazard_unit_mc_if #(.REG_AW(5), .CNT_W(3))  hz3 ();

    hazard_unit_mc #(
        .REG_AW  (5),
        .MDU_LAT (4),
        .CNT_W   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    hazard_unit_mc #(
        .REG_AW  (5),
        .MDU_LAT (4),
        .CNT_W   (3)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.BranchD   = 0; hz.PcSrcD    = 0;
        hz.RsD       = 0; hz.RtD       = 0;
        hz.RsE       = 0; hz.RtE       = 0;
        hz.WriteRegE = 0; hz.WriteRegM = 0;
        hz.WriteRegW = 0; hz.RegWriteE = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemtoRegE = 0; hz.MemtoRegM = 0;
        hz.MemReqM   = 0; hz.MemReadyM = 0;
        hz.MduStartE = 0; hz.MduUseD   = 0;
    endtask

    task automatic clr3();
        hz3.BranchD   = 0; hz3.PcSrcD    = 0;
        hz3.RsD       = 0; hz3.RtD       = 0;
        hz3.RsE       = 0; hz3.RtE       = 0;
        hz3.WriteRegE = 0; hz3.WriteRegM = 0;
        hz3.WriteRegW = 0; hz3.RegWriteE = 0;
        hz3.RegWriteM = 0; hz3.RegWriteW = 0;
        hz3.MemtoRegE = 0; hz3.MemtoRegM = 0;
        hz3.MemReqM   = 0; hz3.MemReadyM = 0;
        hz3.MduStartE = 0; hz3.MduUseD   = 0;
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        reset = 1'b1;
        clr();
        clr3();
        tick();
        check("rst_busy", hz.MduBusy, 0);
        check("rst_cnt", hz.StallCount, 0);
        check("rst_stallf", hz.StallF, 0);
        check("rst_fwdae", hz.ForwardAE, 0);
        check("rst_flushd", hz.FlushD, 0);
        tick();
        reset = 1'b0;

        // load-use: lw $2 in E, RsD=2
        hz.MemtoRegE = 1; hz.RtE = 2; hz.RsD = 2;
        #1;
        check("lw_stallf", hz.StallF, 1);
        check("lw_stalld", hz.StallD, 1);
        check("lw_flushe", hz.FlushE, 1);
        check("lw_stalle", hz.StallE, 0);
        check("lw_flushd", hz.FlushD, 0);
        tick();
        clr();
        hz.RsE = 2; hz.WriteRegW = 2; hz.RegWriteW = 1;
        #1;
        check("lw_fwd_w", hz.ForwardAE, 2'b01);
        check("lw_nostall", hz.StallF, 0);
        check("lw_cnt", hz.StallCount, 1);

        // forwarding priority and register 0
        clr();
        hz.RsE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1;
        hz.WriteRegW = 5; hz.RegWriteW = 1;
        #1;
        check("fwd_m_prio", hz.ForwardAE, 2'b10);
        hz.RegWriteM = 0;
        #1;
        check("fwd_w_nowm", hz.ForwardAE, 2'b01);
        hz.RsE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
        hz.RegWriteM = 1;
        #1;
        check("fwd_r0", hz.ForwardAE, 2'b00);
        clr();
        hz.RtE = 9; hz.WriteRegW = 9; hz.RegWriteW = 1;
        hz.WriteRegM = 8; hz.RegWriteM = 1;
        #1;
        check("fwd_be_w", hz.ForwardBE, 2'b01);
        check("fwd_ae_none", hz.ForwardAE, 2'b00);
        tick();

        // branch depending on ALU result in E
        clr();
        hz.BranchD = 1; hz.RsD = 3;
        hz.WriteRegE = 3; hz.RegWriteE = 1;
        #1;
        check("br_stallf", hz.StallF, 1);
        check("br_flushe", hz.FlushE, 1);
        tick();
        check("br_cnt", hz.StallCount, 2);
        hz.RegWriteE = 0; hz.WriteRegE = 0;
        hz.WriteRegM = 3; hz.RegWriteM = 1;
        #1;
        check("br_fwdad", hz.ForwardAD, 1);
        check("br_fwdbd", hz.ForwardBD, 0);
        check("br_nostall", hz.StallF, 0);
        hz.PcSrcD = 1;
        #1;
        check("br_flushd", hz.FlushD, 1);
        tick();
        // taken branch still stalled: no flush yet
        clr();
        hz.BranchD = 1; hz.PcSrcD = 1; hz.RtD = 7;
        hz.WriteRegM = 7; hz.MemtoRegM = 1;
        #1;
        check("brm_stallf", hz.StallF, 1);
        check("brm_flushd", hz.FlushD, 0);
        tick();
        check("brm_cnt", hz.StallCount, 3);

        // MDU occupancy
        clr();
        hz.MduStartE = 1;
        #1;
        check("mdu_idle", hz.MduBusy, 0);
        tick();
        hz.MduStartE = 0; hz.MduUseD = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mdu_busy%0d", i), hz.MduBusy, 1);
            check($sformatf("mdu_stalld%0d", i), hz.StallD, 1);
            tick();
        end
        #1;
        check("mdu_done", hz.MduBusy, 0);
        check("mdu_free", hz.StallD, 0);
        check("mdu_cnt", hz.StallCount, 7);

        // reset mid-operation
        clr();
        hz.MduStartE = 1;
        tick();
        hz.MduStartE = 0; hz.MduUseD = 1;
        tick();
        check("mdur_busy", hz.MduBusy, 1);
        reset = 1'b1;
        #1;
        check("mdur_abort", hz.MduBusy, 0);
        check("mdur_stalld", hz.StallD, 0);
        check("mdur_cnt", hz.StallCount, 0);
        clr();
        tick();
        reset = 1'b0;

        // memory wait states over a load-use hazard
        hz.MemReqM = 1; hz.MemReadyM = 0;
        hz.MemtoRegE = 1; hz.RtE = 2; hz.RsD = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mem_sf%0d", i), hz.StallF, 1);
            check($sformatf("mem_sm%0d", i), hz.StallM, 1);
            check($sformatf("mem_se%0d", i), hz.StallE, 1);
            check($sformatf("mem_fw%0d", i), hz.FlushW, 1);
            check($sformatf("mem_fe%0d", i), hz.FlushE, 0);
            tick();
        end
        hz.MemReadyM = 1;
        #1;
        check("memlw_sd", hz.StallD, 1);
        check("memlw_fe", hz.FlushE, 1);
        check("memlw_sm", hz.StallM, 0);
        check("memlw_fw", hz.FlushW, 0);
        tick();
        clr();
        #1;
        check("memlw_cnt", hz.StallCount, 4);

        // saturation on the narrow counter
        hz3.MemReqM = 1;
        for (int i = 0; i < 6; i++) tick();
        check("sat_six", hz3.StallCount, 6);
        for (int i = 0; i < 4; i++) tick();
        check("sat_hold", hz3.StallCount, 7);
        clr3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
